// File: rtl/jogo_playseq_pkg.sv
// Shared types and constants for the sequence-memory game.
// State codes, LFSR taps and win/loss counter width.
package jogo_playseq_pkg;

   typedef enum logic [4:0] {
      INICIAL  = 5'd0,
      GERA     = 5'd1,
      PREP     = 5'd2,
      MOSTRA   = 5'd3,
      APAGA    = 5'd4,
      ESPERA   = 5'd5,
      REGISTRA = 5'd6,
      COMPARA  = 5'd7,
      PROXIMA  = 5'd8,
      GANHOU   = 5'd9,
      PERDEU   = 5'd10
   } estado_t;

   // Taps 16,14,13,11 as bit mask of state bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [15:0] lfsr_passo(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/jogo_playseq_if.sv
// Player-side bundle of the game: controls, buttons, LEDs and results.
interface jogo_playseq_if #(
   parameter int N_BOTOES = 4,
   parameter int PROF     = 16
);
   import jogo_playseq_pkg::*;

   localparam int CW = $clog2(PROF + 1);

   logic                jogar;
   logic [CW-1:0]       comprimento;
   logic [N_BOTOES-1:0] botoes;
   logic                ignora_timeout;
   logic [N_BOTOES-1:0] leds;
   logic                pronto;
   logic                ganhou;
   logic                perdeu;
   logic                timeout;
   logic [CNT_W-1:0]    vitorias;
   logic [CNT_W-1:0]    derrotas;
   logic [4:0]          db_estado;

   modport master (
      output jogar, comprimento, botoes, ignora_timeout,
      input  leds, pronto, ganhou, perdeu, timeout,
      input  vitorias, derrotas, db_estado
   );

   modport slave (
      input  jogar, comprimento, botoes, ignora_timeout,
      output leds, pronto, ganhou, perdeu, timeout,
      output vitorias, derrotas, db_estado
   );

endinterface

// File: rtl/jogo_playseq_lfsr.sv
// 16-bit Fibonacci LFSR with enable and synchronous seed load.
module playseq_lfsr16
   import jogo_playseq_pkg::*;
#(
   parameter logic [15:0] SEMENTE = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        en,
   input  logic        carga,
   input  logic [15:0] semente,
   output logic [15:0] estado
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         estado <= SEMENTE;
      else if (carga)
         estado <= semente;
      else if (en)
         estado <= lfsr_passo(estado);
   end

endmodule

// File: rtl/jogo_playseq_param.sv
// Sequence-memory game: random preview, player echo, win/loss tally.
module jogo_playseq_param
   import jogo_playseq_pkg::*;
#(
   parameter int          N_BOTOES  = 4,
   parameter int          PROF      = 16,
   parameter int          T_TIMEOUT = 5000,
   parameter int          T_LED     = 1000,
   parameter logic [15:0] SEMENTE   = 16'hACE1
) (
   input logic           clock,
   input logic           reset,
   jogo_playseq_if.slave io
);

   localparam int IW   = (N_BOTOES > 2) ? $clog2(N_BOTOES) : 1;
   localparam int AW   = $clog2(PROF + 1);
   localparam int MW   = $clog2(PROF);
   localparam int TMAX = (T_TIMEOUT > T_LED) ? T_TIMEOUT : T_LED;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [AW-1:0] PROF_A   = AW'(PROF);
   localparam logic [AW-1:0] GERA_FIM = AW'(PROF - 1);
   localparam logic [TW-1:0] LED_FIM  = TW'(T_LED - 1);
   localparam logic [TW-1:0] TO_FIM   = TW'(T_TIMEOUT - 1);

   estado_t             estado, prox;
   logic [15:0]         lfsr;
   logic [IW-1:0]       mem [PROF];
   logic [AW-1:0]       addr, rodada, len, len_eff;
   logic [TW-1:0]       tempo;
   logic [N_BOTOES-1:0] botoes_q, jogada, alvo, leds_c;
   logic [CNT_W-1:0]    vit, der;
   logic                perdeu_to;
   logic                jogada_nova, acerto, ultimo;
   logic                fim_led, fim_to;

   playseq_lfsr16 #(.SEMENTE(SEMENTE)) u_lfsr (
      .clock   (clock),
      .reset   (reset),
      .en      (1'b1),
      .carga   (1'b0),
      .semente (SEMENTE),
      .estado  (lfsr)
   );

   assign len_eff = (io.comprimento == '0 ||
                     io.comprimento > PROF_A) ?
                    PROF_A : io.comprimento;

   assign alvo        = N_BOTOES'(1) << mem[addr[MW-1:0]];
   assign acerto      = (jogada == alvo);
   assign ultimo      = (addr == rodada - 1'b1);
   assign fim_led     = (tempo == LED_FIM);
   assign fim_to      = (tempo == TO_FIM);
   // Only a 0 -> nonzero transition counts; held buttons never do
   assign jogada_nova = (|io.botoes) & ~(|botoes_q);

   always_comb begin
      prox   = estado;
      leds_c = '0;
      unique case (estado)
         INICIAL, GANHOU, PERDEU:
            if (io.jogar) prox = GERA;
         GERA:
            if (addr == GERA_FIM) prox = PREP;
         PREP:
            prox = MOSTRA;
         MOSTRA: begin
            leds_c = alvo;
            if (fim_led) prox = APAGA;
         end
         APAGA:
            if (fim_led) prox = ultimo ? ESPERA : MOSTRA;
         ESPERA: begin
            leds_c = io.botoes;
            if (jogada_nova)
               prox = REGISTRA;
            else if (fim_to && !io.ignora_timeout)
               prox = PERDEU;
         end
         REGISTRA: begin
            leds_c = jogada;
            prox   = COMPARA;
         end
         COMPARA: begin
            leds_c = jogada;
            if (!acerto)           prox = PERDEU;
            else if (!ultimo)      prox = ESPERA;
            else if (rodada == len) prox = GANHOU;
            else                   prox = PROXIMA;
         end
         PROXIMA:
            prox = PREP;
         default:
            prox = INICIAL;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado    <= INICIAL;
         addr      <= '0;
         rodada    <= '0;
         len       <= '0;
         tempo     <= '0;
         botoes_q  <= '0;
         jogada    <= '0;
         perdeu_to <= 1'b0;
         vit       <= '0;
         der       <= '0;
      end else begin
         estado   <= prox;
         botoes_q <= io.botoes;
         case (estado)
            INICIAL, GANHOU, PERDEU:
               if (io.jogar) begin
                  len       <= len_eff;
                  rodada    <= AW'(1);
                  addr      <= '0;
                  perdeu_to <= 1'b0;
               end
            GERA:
               addr <= addr + 1'b1;
            PREP: begin
               addr  <= '0;
               tempo <= '0;
            end
            MOSTRA:
               tempo <= fim_led ? '0 : tempo + 1'b1;
            APAGA:
               if (fim_led) begin
                  tempo <= '0;
                  addr  <= ultimo ? '0 : addr + 1'b1;
               end else begin
                  tempo <= tempo + 1'b1;
               end
            ESPERA:
               if (jogada_nova) begin
                  jogada <= io.botoes;
                  tempo  <= '0;
               end else if (!io.ignora_timeout) begin
                  if (fim_to) perdeu_to <= 1'b1;
                  else        tempo <= tempo + 1'b1;
               end
            COMPARA:
               if (acerto && !ultimo) begin
                  addr  <= addr + 1'b1;
                  tempo <= '0;
               end
            PROXIMA:
               rodada <= rodada + 1'b1;
            default: ;
         endcase
         if (prox == GANHOU && estado != GANHOU && vit != CNT_MAX)
            vit <= vit + 1'b1;
         if (prox == PERDEU && estado != PERDEU && der != CNT_MAX)
            der <= der + 1'b1;
      end
   end

   // Sequence storage is fully rewritten by GERA before any read
   always_ff @(posedge clock) begin
      if (estado == GERA)
         mem[addr[MW-1:0]] <= IW'(lfsr % 16'(N_BOTOES));
   end

   assign io.leds      = leds_c;
   assign io.ganhou    = (estado == GANHOU);
   assign io.perdeu    = (estado == PERDEU);
   assign io.pronto    = (estado == GANHOU) || (estado == PERDEU);
   assign io.timeout   = (estado == PERDEU) && perdeu_to;
   assign io.vitorias  = vit;
   assign io.derrotas  = der;
   assign io.db_estado = estado;

endmodule

// File: tb/tb_jogo_playseq_param.sv
// Directed bench for jogo_playseq_param (N=4, PROF=4, timeout 20, LED 3).
module tb_jogo_playseq_param;
   import jogo_playseq_pkg::*;

   localparam int NB  = 4;
   localparam int PR  = 4;
   localparam int TTO = 20;
   localparam int TL  = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;

   jogo_playseq_if #(.N_BOTOES(NB), .PROF(PR)) io ();

   jogo_playseq_param #(
      .N_BOTOES(NB), .PROF(PR), .T_TIMEOUT(TTO),
      .T_LED(TL), .SEMENTE(16'hACE1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .io    (io)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Reference LFSR: taps 16,14,13,11, stepping every clock from the seed
   logic [15:0] m;
   always @(posedge clock or negedge reset) begin
      if (!reset) m <= 16'hACE1;
      else        m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
   end

   function automatic logic [15:0] passo(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Expected entries of the game being generated
   logic [3:0] esp [PR];
   int g = 0;
   always @(negedge clock) begin
      if (io.db_estado == 5'd1) begin
         if (g < PR) esp[g] = 4'b0001 << m[1:0];
         g = g + 1;
      end else begin
         g = 0;
      end
   end

   logic [3:0] vista [PR];
   logic [3:0] seq_a [PR];

   task automatic espera(input logic [4:0] s, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clock);
         if (io.db_estado == s) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic assistir(input int r, output bit ok);
      bit o;
      ok = 1'b1;
      for (int k = 0; k < r; k++) begin
         espera(MOSTRA, 100, o);
         ok &= o;
         vista[k] = io.leds;
         espera(APAGA, 10, o);
         ok &= o;
      end
      espera(ESPERA, 10, o);
      ok &= o;
   endtask

   task automatic apertar(input logic [3:0] v);
      io.botoes = v;
      repeat (2) @(negedge clock);
      io.botoes = '0;
      @(negedge clock);
   endtask

   task automatic iniciar(input logic [2:0] c);
      io.comprimento = c;
      io.jogar = 1'b1;
      @(negedge clock);
      io.jogar = 1'b0;
   endtask

   task automatic partida(input int len, output bit ok);
      bit o;
      ok = 1'b1;
      for (int r = 1; r <= len; r++) begin
         assistir(r, o);
         ok &= o;
         for (int k = 0; k < r; k++) apertar(vista[k]);
      end
   endtask

   task automatic test_reset;
      io.jogar = 1'b0;
      io.comprimento = '0;
      io.botoes = '0;
      io.ignora_timeout = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      n_cmp++;
      if (io.db_estado !== 5'd0) begin
         n_err++;
         $display("FAIL reset_estado got=%0d exp=0", io.db_estado);
      end
      n_cmp++;
      if (io.leds !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_leds got=%b exp=0000", io.leds);
      end
      n_cmp++;
      if ({io.pronto, io.ganhou, io.perdeu, io.timeout} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_flags got=%b exp=0000",
                  {io.pronto, io.ganhou, io.perdeu, io.timeout});
      end
      n_cmp++;
      if (io.vitorias !== 8'd0 || io.derrotas !== 8'd0) begin
         n_err++;
         $display("FAIL reset_contadores got=%0d/%0d exp=0/0",
                  io.vitorias, io.derrotas);
      end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_vitoria;
      bit ok;
      logic [3:0] primeiro;
      iniciar(3'd2);
      assistir(1, ok);
      primeiro = vista[0];
      n_cmp++;
      if (ok !== 1'b1 || vista[0] !== esp[0]) begin
         n_err++;
         $display("FAIL previa_r1 got=%b exp=%b ok=%0b", vista[0], esp[0], ok);
      end
      apertar(vista[0]);
      assistir(2, ok);
      n_cmp++;
      if (ok !== 1'b1 || vista[0] !== primeiro || vista[1] !== esp[1]) begin
         n_err++;
         $display("FAIL previa_r2 got=%b,%b exp=%b,%b ok=%0b",
                  vista[0], vista[1], primeiro, esp[1], ok);
      end
      apertar(vista[0]);
      apertar(vista[1]);
      n_cmp++;
      if ({io.ganhou, io.pronto, io.perdeu} !== 3'b110) begin
         n_err++;
         $display("FAIL vitoria_flags got=%b exp=110",
                  {io.ganhou, io.pronto, io.perdeu});
      end
      n_cmp++;
      if (io.vitorias !== 8'd1) begin
         n_err++;
         $display("FAIL vitoria_contador got=%0d exp=1", io.vitorias);
      end
   endtask

   task automatic test_erro;
      bit ok;
      logic [3:0] rot;
      iniciar(3'd3);
      assistir(1, ok);
      apertar(vista[0]);
      assistir(2, ok);
      apertar(vista[0]);
      rot = {vista[1][2:0], vista[1][3]};
      io.botoes = rot;
      @(negedge clock);
      n_cmp++;
      if (io.db_estado !== 5'd6 || io.leds !== rot) begin
         n_err++;
         $display("FAIL eco got=%0d/%b exp=6/%b", io.db_estado, io.leds, rot);
      end
      @(negedge clock);
      io.botoes = '0;
      @(negedge clock);
      n_cmp++;
      if ({io.perdeu, io.pronto, io.timeout} !== 3'b110) begin
         n_err++;
         $display("FAIL erro_flags got=%b exp=110",
                  {io.perdeu, io.pronto, io.timeout});
      end
      n_cmp++;
      if (io.derrotas !== 8'd1 || io.vitorias !== 8'd1) begin
         n_err++;
         $display("FAIL erro_contadores got=%0d/%0d exp=1/1",
                  io.derrotas, io.vitorias);
      end
   endtask

   task automatic test_timeout;
      bit ok;
      int n;
      iniciar(3'd2);
      assistir(1, ok);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (io.db_estado != 5'd5) break;
         n++;
         if (i == 5) io.jogar = 1'b1;
         if (i == 8) io.jogar = 1'b0;
         @(negedge clock);
      end
      io.jogar = 1'b0;
      n_cmp++;
      if (n !== TTO) begin
         n_err++;
         $display("FAIL tempo_limite got=%0d exp=%0d", n, TTO);
      end
      n_cmp++;
      if ({io.perdeu, io.timeout} !== 2'b11 || io.derrotas !== 8'd2) begin
         n_err++;
         $display("FAIL timeout_flags got=%b/%0d exp=11/2",
                  {io.perdeu, io.timeout}, io.derrotas);
      end
      iniciar(3'd2);
      assistir(1, ok);
      io.ignora_timeout = 1'b1;
      repeat (100) @(negedge clock);
      n_cmp++;
      if (io.db_estado !== 5'd5 || io.perdeu !== 1'b0) begin
         n_err++;
         $display("FAIL congelado got=%0d exp=5", io.db_estado);
      end
      io.ignora_timeout = 1'b0;
      apertar(4'b0011);
      n_cmp++;
      if ({io.perdeu, io.timeout} !== 2'b10 || io.derrotas !== 8'd3) begin
         n_err++;
         $display("FAIL multi_hot got=%b/%0d exp=10/3",
                  {io.perdeu, io.timeout}, io.derrotas);
      end
   endtask

   task automatic test_comprimento0;
      bit ok;
      int rod;
      io.botoes = 4'b1111;
      iniciar(3'd0);
      assistir(1, ok);
      repeat (3) @(negedge clock);
      n_cmp++;
      if (io.db_estado !== 5'd5) begin
         n_err++;
         $display("FAIL botao_preso got=%0d exp=5", io.db_estado);
      end
      io.botoes = '0;
      @(negedge clock);
      apertar(vista[0]);
      rod = ok ? 1 : 0;
      for (int r = 2; r <= PR; r++) begin
         assistir(r, ok);
         if (ok) rod++;
         for (int k = 0; k < r; k++) apertar(vista[k]);
      end
      n_cmp++;
      if (rod !== PR || io.ganhou !== 1'b1 || io.vitorias !== 8'd2) begin
         n_err++;
         $display("FAIL comprimento0 got=%0d/%0b/%0d exp=%0d/1/2",
                  rod, io.ganhou, io.vitorias, PR);
      end
   endtask

   task automatic test_reset_meio;
      bit ok;
      iniciar(3'd2);
      espera(MOSTRA, 100, ok);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (ok !== 1'b1 || io.db_estado !== 5'd0 || io.leds !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_meio got=%0d/%b exp=0/0000",
                  io.db_estado, io.leds);
      end
      n_cmp++;
      if (io.vitorias !== 8'd0 || io.derrotas !== 8'd0) begin
         n_err++;
         $display("FAIL reset_meio_cont got=%0d/%0d exp=0/0",
                  io.vitorias, io.derrotas);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_saturacao;
      bit ok, todas;
      todas = 1'b1;
      for (int i = 0; i < 256; i++) begin
         iniciar(3'd1);
         assistir(1, ok);
         apertar(vista[0]);
         todas &= ok & io.ganhou;
      end
      n_cmp++;
      if (todas !== 1'b1) begin
         n_err++;
         $display("FAIL partidas_forcadas got=0 exp=1");
      end
      n_cmp++;
      if (io.vitorias !== 8'd255) begin
         n_err++;
         $display("FAIL saturacao got=%0d exp=255", io.vitorias);
      end
   endtask

   task automatic test_sequencias;
      bit ok, igual;
      logic [15:0] s;
      iniciar(3'd4);
      partida(PR, ok);
      seq_a = vista;
      n_cmp++;
      if (ok !== 1'b1 || seq_a != esp || io.ganhou !== 1'b1) begin
         n_err++;
         $display("FAIL seq_a got=%b%b%b%b exp=%b%b%b%b", seq_a[0],
                  seq_a[1], seq_a[2], seq_a[3], esp[0], esp[1], esp[2], esp[3]);
      end
      // Start game B where the reference stream gives a different window
      for (int t = 0; t < 16; t++) begin
         s = m;
         igual = 1'b1;
         for (int k = 0; k < PR; k++) begin
            s = passo(s);
            if ((4'b0001 << s[1:0]) != seq_a[k]) igual = 1'b0;
         end
         if (!igual) break;
         @(negedge clock);
      end
      iniciar(3'd4);
      partida(PR, ok);
      n_cmp++;
      if (ok !== 1'b1 || vista != esp) begin
         n_err++;
         $display("FAIL seq_b got=%b%b%b%b exp=%b%b%b%b", vista[0],
                  vista[1], vista[2], vista[3], esp[0], esp[1], esp[2], esp[3]);
      end
      n_cmp++;
      if (vista == seq_a) begin
         n_err++;
         $display("FAIL seq_distintas got=%b%b%b%b exp=diferente",
                  vista[0], vista[1], vista[2], vista[3]);
      end
   endtask

   initial begin
      test_reset;
      test_vitoria;
      test_erro;
      test_timeout;
      test_comprimento0;
      test_reset_meio;
      test_saturacao;
      test_sequencias;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/jogo_playseq_param.md
JOGO_PLAYSEQ_PARAM -- requirements
Module: jogo_playseq_param

Interface
REQ-001 Parameter N_BOTOES, default 4: number of button/LED channels, range 2..16.
REQ-002 Parameter PROF, default 16: maximum sequence depth, range 2..64.
REQ-003 Parameter T_TIMEOUT, default 5000: clock cycles allowed per move.
REQ-004 Parameter T_LED, default 1000: clock cycles a preview LED stays on, and then stays off.
REQ-005 Parameter SEMENTE, default 16'hACE1: nonzero LFSR seed.
REQ-006 clock  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 jogar  in  1  start or restart request, level-sampled.
REQ-009 comprimento  in  $clog2(PROF+1)  target sequence length; sampled on start.
REQ-010 botoes  in  N_BOTOES  player buttons, synchronous to clock.
REQ-011 ignora_timeout  in  1  when 1, the move timer is frozen.
REQ-012 leds  out  N_BOTOES  one-hot preview or echo display.
REQ-013 pronto, ganhou, perdeu, timeout  out  1 each  end-of-game flags.
REQ-014 vitorias, derrotas  out  8 each  saturating win/loss counters.
REQ-015 db_estado  out  5  current FSM state code.

Function
REQ-016 FSM states, in order: INICIAL, GERA, PREP, MOSTRA, APAGA, ESPERA, REGISTRA, COMPARA, PROXIMA, GANHOU, PERDEU.
REQ-017 INICIAL, GANHOU or PERDEU with jogar=1 SHALL go to GERA and latch the effective length L; L = comprimento, or PROF if comprimento is 0 or greater than PROF.
REQ-018 GERA SHALL take exactly PROF cycles, writing entry i = (16-bit Fibonacci LFSR, taps 16,14,13,11) mod N_BOTOES; LFSR steps every cycle and is never reset by jogar, so every game has a new sequence.
REQ-019 Round r (1..L): PREP clears the address counter; MOSTRA and APAGA alternate, each lasting T_LED cycles, for entries 0..r-1; leds = one-hot(entry) in MOSTRA, 0 in APAGA; then ESPERA.
REQ-020 A move SHALL be the cycle where botoes goes from 0 to nonzero (registered edge); REGISTRA latches botoes and leds echoes them while held.
REQ-021 COMPARA: latched value == one-hot(entry[addr]) is a match; a multi-hot value is a mismatch.
REQ-022 Mismatch -> PERDEU; match with addr<r-1 -> addr+1, then ESPERA; match with addr==r-1 and r==L -> GANHOU; otherwise PROXIMA, then r+1 and PREP.
REQ-023 In ESPERA the timer counts 0..T_TIMEOUT-1 and clears on each move; reaching T_TIMEOUT-1 with ignora_timeout=0 -> PERDEU with timeout=1.
REQ-024 GANHOU: ganhou=1 and pronto=1, held until exit; vitorias increments once on entry and saturates at 255.
REQ-025 PERDEU: perdeu=1 and pronto=1, held until exit; derrotas increments once on entry and saturates at 255; timeout=1 only if the loss was a timeout.
REQ-026 Button activity outside ESPERA SHALL be ignored; buttons held across the entry into ESPERA SHALL NOT count as a move until released.
REQ-027 jogar in any in-game state SHALL be ignored.

Reset
REQ-028 Reset low SHALL immediately force INICIAL, clear leds, all flags, both counters, round, address and timer, and load the LFSR with SEMENTE, including in mid-game.
REQ-029 Sequence memory contents need no reset.

Structure
REQ-030 A shared package jogo_playseq_pkg SHALL hold the FSM state enum/codes, LFSR tap constant and counter width constant.
REQ-031 The sub-module playseq_lfsr16 SHALL implement the LFSR (enable, seed load, 16-bit state out).
REQ-032 Sequence memory, timers and FSM SHALL live in jogo_playseq_param; no latches, no gated clocks.

Verification (N_BOTOES=4, PROF=4, T_TIMEOUT=20, T_LED=3)
REQ-033 Reset, jogar, comprimento=2, echo each preview LED pattern -> preview of 1 then 2 LEDs, ganhou=1, pronto=1, vitorias=1.
REQ-034 comprimento=3, round 2 second move wrong (leds pattern rotated) -> perdeu=1, timeout=0, derrotas=1, vitorias unchanged.
REQ-035 No move for 20 cycles in ESPERA -> perdeu=1, timeout=1; repeat with ignora_timeout=1 for 100 cycles -> still ESPERA.
REQ-036 Press 4'b0011 in ESPERA -> PERDEU; comprimento=0 -> 4 rounds played (L=PROF).
REQ-037 Reset pulsed low during MOSTRA -> INICIAL next cycle, leds=0, counters=0; 256 forced wins -> vitorias stays 255.
REQ-038 Two consecutive games with no reset between them -> preview sequences differ.
